// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 Hz raster constants and count types, also used by the sprite
// controllers to bound their X0/Y0 positions.
package vga_timing_gen_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_CLK_DIV     = 4;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_VIS_START = 144;
  localparam int VGA_H_VIS       = 640;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_VIS_START = 35;
  localparam int VGA_V_VIS       = 480;
  localparam int VGA_PIPE_DLY    = 1;

  typedef logic [CNT_W-1:0] cnt_t;
  // One extra bit so a window ending exactly at 1024 stays representable.
  typedef logic [CNT_W:0]   wcnt_t;

  function automatic logic in_window(cnt_t val, wcnt_t lo, wcnt_t hi);
    return ({1'b0, val} >= lo) && ({1'b0, val} < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus between the timing generator (master) and its consumers (slave).
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  logic en;
  cnt_t hCount;
  cnt_t vCount;
  logic bright;
  logic pix_en;
  logic line_start;
  logic frame_start;
  logic hSync_o;
  logic vSync_o;

  modport master (
    input  en,
    output hCount, vCount, bright, pix_en, line_start, frame_start, hSync_o, vSync_o
  );

  modport slave (
    output en,
    input  hCount, vCount, bright, pix_en, line_start, frame_start, hSync_o, vSync_o
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Shift-register delay for an active-low sync line; every stage resets to the
// inactive level so a reset flushes the pipe instead of holding stale syncs.
module sync_delay #(
  parameter int PIPE_DLY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  generate
    if (PIPE_DLY == 0) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      logic [PIPE_DLY-1:0] sync_p;

      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_p <= '1;
        end else begin
          sync_p[0] <= din;
          for (int i = 1; i < PIPE_DLY; i++) begin
            sync_p[i] <= sync_p[i-1];
          end
        end
      end

      assign dout = sync_p[PIPE_DLY-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter for the VGA path: pixel-rate tick from the system clock,
// h/v counts, visible-region flag, line/frame pulses and delayed syncs.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_VIS_START = VGA_H_VIS_START,
  parameter int H_VIS       = VGA_H_VIS,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_VIS_START = VGA_V_VIS_START,
  parameter int V_VIS       = VGA_V_VIS,
  parameter int PIPE_DLY    = VGA_PIPE_DLY
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam cnt_t  H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t  V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t  H_SYNC_C = cnt_t'(H_SYNC);
  localparam cnt_t  V_SYNC_C = cnt_t'(V_SYNC);
  localparam wcnt_t H_LO = wcnt_t'(H_VIS_START);
  localparam wcnt_t H_HI = wcnt_t'(H_VIS_START + H_VIS);
  localparam wcnt_t V_LO = wcnt_t'(V_VIS_START);
  localparam wcnt_t V_HI = wcnt_t'(V_VIS_START + V_VIS);

  logic [DIV_W-1:0] div_q;
  cnt_t             h_q;
  cnt_t             v_q;
  logic             line_q;
  logic             frame_q;
  logic             pix_en;
  logic             h_wrap;
  logic             v_wrap;
  logic             hsync_raw;
  logic             vsync_raw;

  assign pix_en = vga.en && (div_q == DIV_LAST);
  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      if (vga.en) begin
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
      if (pix_en) begin
        if (h_wrap) begin
          h_q <= '0;
          v_q <= v_wrap ? '0 : v_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
      end
      // Registered so the pulse lands in the first clk showing hCount==0.
      line_q  <= pix_en && h_wrap;
      frame_q <= pix_en && h_wrap && v_wrap;
    end
  end

  assign hsync_raw = !(h_q < H_SYNC_C);
  assign vsync_raw = !(v_q < V_SYNC_C);

  // Syncs are delayed to line up with the registered sprite/ROM pipelines.
  sync_delay #(.PIPE_DLY(PIPE_DLY)) u_hsync (
    .clk  (clk),
    .rst  (rst),
    .din  (hsync_raw),
    .dout (vga.hSync_o)
  );

  sync_delay #(.PIPE_DLY(PIPE_DLY)) u_vsync (
    .clk  (clk),
    .rst  (rst),
    .din  (vsync_raw),
    .dout (vga.vSync_o)
  );

  assign vga.hCount      = h_q;
  assign vga.vCount      = v_q;
  assign vga.bright      = in_window(h_q, H_LO, H_HI) && in_window(v_q, V_LO, V_HI);
  assign vga.pix_en      = pix_en;
  assign vga.line_start  = line_q && vga.en;
  assign vga.frame_start = frame_q && vga.en;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates the 640x480@60 Hz raster that every sprite/prompt controller consumes: hCount, vCount, bright, hSync and vSync. Runs on the 100 MHz system clock with a 25 MHz pixel-enable tick. Sync outputs have a configurable delay so they stay aligned with the one-cycle-registered sprite/ROM pipelines. It sits at the top of the VGA path and fans out to all controllers and to the board's VGA pins.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=2)
H_TOTAL, 800, pixels per line incl. blanking
H_SYNC, 96, hSync low width (hCount 0..H_SYNC-1)
H_VIS_START, 144, first visible hCount
H_VIS, 640, visible pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vSync low width (vCount 0..V_SYNC-1)
V_VIS_START, 35, first visible vCount
V_VIS, 480, visible lines
PIPE_DLY, 1, system-clock delay applied to hSync_o/vSync_o (0..3)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-low
en  in  1  run enable; low freezes the raster
hCount  out  10  horizontal count, 0..H_TOTAL-1
vCount  out  10  vertical count, 0..V_TOTAL-1
bright  out  1  visible-region flag, aligned with hCount/vCount
pix_en  out  1  one-clk tick at pixel rate
line_start  out  1  one-clk pulse, first clk of hCount==0
frame_start  out  1  one-clk pulse, first clk of hCount==0 && vCount==0
hSync_o  out  1  delayed hSync, active-low, to pin
vSync_o  out  1  delayed vSync, active-low, to pin

Behaviour:
- Reset (rst==0 at posedge): div counter=0, hCount=0, vCount=0, pix_en=0, line_start=0, frame_start=0, and every delay stage of hSync_o/vSync_o=1 (inactive). The sync pipeline is flushed, not held. Takes effect mid-frame at the next edge.
- Divider: div counts 0..CLK_DIV-1 while en=1. pix_en is high in the clk where div==CLK_DIV-1 and en=1, otherwise low.
- On pix_en, hCount increments. At hCount==H_TOTAL-1 it wraps to 0 and vCount increments. At vCount==V_TOTAL-1 coinciding with the h-wrap, vCount wraps to 0. Counts change only on pix_en, so each value is held for CLK_DIV clks.
- en=0: div, hCount and vCount hold. pix_en, line_start and frame_start are 0. Sync outputs keep tracking the held counts. When en returns high, div resumes from its held value.
- line_start is registered and high for exactly one clk: the clk in which hCount has just become 0 after a wrap. frame_start follows the same rule, additionally requiring vCount==0. Neither pulses after reset; the first pulse comes after the first wrap.
- bright = (H_VIS_START <= hCount < H_VIS_START+H_VIS) && (V_VIS_START <= vCount < V_VIS_START+V_VIS). It is combinational from the registered counts, with zero lag relative to them.
- Raw hSync = !(hCount < H_SYNC); raw vSync = !(vCount < V_SYNC). hSync_o/vSync_o are the raw signals delayed PIPE_DLY clks through a shift register. PIPE_DLY=0 means a direct combinational path.
- Widths: internal compares are unsigned 10-bit. Parameters must satisfy H_VIS_START+H_VIS <= H_TOTAL <= 1024 and the same for V.

Decomposition:
- Shared package/header vga_params: the 640x480 timing constants (H_TOTAL, H_SYNC, H_VIS_START, H_VIS, V_*), the 10-bit count width, and CLK_DIV. Sprite controllers use the same constants to bound X0/Y0.
- One natural sub-module: sync_delay (parameterized PIPE_DLY shift register with reset value 1), instantiated twice.

Test Plan:
- Reset: hold rst=0 for 5 clks -> hCount=0, vCount=0, pix_en=0, hSync_o=1, vSync_o=1. Release -> first pix_en at clk 4; hCount=1 at clk 5.
- Cadence: run 40 clks with en=1 -> pix_en pulses exactly every 4 clks and hCount increments only on those pulses. Drop en for 10 clks -> counts and div frozen, no pix_en; resume continues without skipping.
- Line/frame wrap: advance to hCount=799, vCount=524 -> next pix_en gives (0,0), vCount increments only at h-wrap, line_start=1 and frame_start=1 for exactly 1 clk each. At (799,10)->(0,11), only line_start pulses.
- Bright edges: hCount 143/144/783/784 at vCount=100 -> bright 0/1/1/0. vCount 34/35/514/515 at hCount=300 -> 0/1/1/0.
- Sync widths and delay: hSync_o low for exactly 96 pixel periods, starting PIPE_DLY clks after hCount becomes 0; vSync_o low for 2 full lines. Repeat with PIPE_DLY=0 and PIPE_DLY=2.
- Mid-frame reset: assert rst at (400,200) for 1 clk -> next clk counts are (0,0), sync pipeline all 1s, no frame_start pulse.
